// File: rtl/counter_param.sv
// counter_param: parametrised up/down counter with prescaler, parallel load,
// wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module counter_param #(
    parameter int unsigned          WIDTH    = 8,
    parameter longint unsigned      MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned          PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX     = MAX_VAL[WIDTH-1:0];
    localparam logic [PW-1:0]    PRE_TOP = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step, at_bound;
    logic [WIDTH-1:0] stepped;

    assign step     = en && (pre_q == PRE_TOP);
    assign at_bound = up_dn ? (count_q == MAX) : (count_q == '0);
    // Boundary value depends on mode: saturate holds, wrap jumps to the opposite end.
    assign stepped  = at_bound ? (sat_mode ? count_q : (up_dn ? '0 : MAX))
                               : (up_dn ? count_q + 1'b1 : count_q - 1'b1);

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            pre_d   = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX) ? MAX : load_val;
            pre_d   = '0;
        end else if (en) begin
            pre_d   = step ? '0 : PW'(pre_q + 1'b1);
            count_d = step ? stepped : count_q;
            tc_d    = step && at_bound;
            ovf_d   = ovf_q || (step && at_bound);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign zero  = (count_q == '0);
endmodule

// File: tb/tb_counter_param.sv
// tb_counter_param: two counters (prescale 1 and 4, modulus 10) driven in
// parallel and checked against an arithmetic reference model every cycle.
module tb_counter_param;
    localparam int MAXV = 9;
    localparam int PS[2] = '{1, 4};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0, sat_mode = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] cnt_o [2];
    logic [1:0] tc_o, ovf_o, zero_o;

    int n_vec = 0;
    int n_err = 0;
    int m_cnt[2], m_ecnt[2], m_tc[2], m_ovf[2];

    always #5 clk = ~clk;

    counter_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .count(cnt_o[0]), .tc(tc_o[0]),
        .ovf(ovf_o[0]), .zero(zero_o[0]));

    counter_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .count(cnt_o[1]), .tc(tc_o[1]),
        .ovf(ovf_o[1]), .zero(zero_o[1]));

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference: a step happens on every PS-th enabled clock since the last restart.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_cnt[k] = 0; m_ecnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
            end else if (clr) begin
                m_cnt[k] = 0; m_ecnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
            end else if (load) begin
                m_cnt[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
                m_ecnt[k] = 0; m_tc[k] = 0;
            end else begin
                m_tc[k] = 0;
                if (en) begin
                    m_ecnt[k]++;
                    if (m_ecnt[k] % PS[k] == 0) begin
                        int bnd;
                        int nxt;
                        bnd = up_dn ? int'(m_cnt[k] == MAXV) : int'(m_cnt[k] == 0);
                        nxt = up_dn ? (m_cnt[k] + 1) % (MAXV + 1) : (m_cnt[k] + MAXV) % (MAXV + 1);
                        m_cnt[k] = (bnd != 0 && sat_mode) ? m_cnt[k] : nxt;
                        m_tc[k] = bnd;
                        if (bnd != 0) m_ovf[k] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("count[%0d]", k), int'(cnt_o[k]), m_cnt[k]);
            chk($sformatf("tc[%0d]", k), int'(tc_o[k]), m_tc[k]);
            chk($sformatf("ovf[%0d]", k), int'(ovf_o[k]), m_ovf[k]);
            chk($sformatf("zero[%0d]", k), int'(zero_o[k]), int'(m_cnt[k] == 0));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(3);
        chk("rst count", int'(cnt_o[0]), 0);
        chk("rst zero", int'(zero_o[0]), 1);
        rst_n = 1'b1; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        tick(9);
        chk("up count 9", int'(cnt_o[0]), 9);
        chk("up ovf pre-wrap", int'(ovf_o[0]), 0);
        tick(1);
        chk("wrap count", int'(cnt_o[0]), 0);
        chk("wrap tc", int'(tc_o[0]), 1);
        chk("wrap ovf", int'(ovf_o[0]), 1);
        tick(1);
        chk("post-wrap tc", int'(tc_o[0]), 0);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr ovf", int'(ovf_o[0]), 0);
        up_dn = 1'b0; sat_mode = 1'b1;
        tick(1);
        chk("sat-down count", int'(cnt_o[0]), 0);
        chk("sat-down tc", int'(tc_o[0]), 1);
        tick(1);
        chk("sat-down tc again", int'(tc_o[0]), 1);
        up_dn = 1'b1;
        tick(3);
        chk("sat then up", int'(cnt_o[0]), 3);
        sat_mode = 1'b0; clr = 1'b1; tick(1); clr = 1'b0;
        tick(3);
        chk("pre4 before step", int'(cnt_o[1]), 0);
        tick(1);
        chk("pre4 first step", int'(cnt_o[1]), 1);
        tick(2);
        en = 1'b0; tick(3);
        chk("pre4 held", int'(cnt_o[1]), 1);
        en = 1'b1; tick(1);
        chk("pre4 delayed", int'(cnt_o[1]), 1);
        tick(1);
        chk("pre4 second step", int'(cnt_o[1]), 2);
        load = 1'b1; load_val = 4'd15; tick(1); load = 1'b0;
        chk("load clamp a", int'(cnt_o[0]), 9);
        chk("load clamp b", int'(cnt_o[1]), 9);
        tick(1);
        chk("post-load wrap ovf", int'(ovf_o[0]), 1);
        load = 1'b1; clr = 1'b1; tick(1); load = 1'b0; clr = 1'b0;
        chk("load+clr count", int'(cnt_o[0]), 0);
        chk("load+clr ovf", int'(ovf_o[0]), 0);
        tick(19);
        chk("run to 9", int'(cnt_o[0]), 9);
        load = 1'b1; load_val = 4'd3; tick(1); load = 1'b0;
        chk("load on bound count", int'(cnt_o[0]), 3);
        chk("load on bound tc", int'(tc_o[0]), 0);
        chk("load on bound ovf", int'(ovf_o[0]), 1);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst count a", int'(cnt_o[0]), 0);
        chk("async rst count b", int'(cnt_o[1]), 0);
        chk("async rst tc", int'(tc_o[0]), 0);
        chk("async rst ovf", int'(ovf_o[0]), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(3);
        chk("post-rst b hold", int'(cnt_o[1]), 0);
        tick(1);
        chk("post-rst b step", int'(cnt_o[1]), 1);
        chk("post-rst a", int'(cnt_o[0]), 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
